// File: rtl/game_pkg.sv
// Shared state encoding and default HID key codes for the barrel-dodge game-flow controller.
package game_pkg;

   typedef enum logic [2:0] {
      TITLE = 3'd0,
      PLAY  = 3'd1,
      PAUSE = 3'd2,
      HIT   = 3'd3,
      OVER  = 3'd4
   } game_state_t;

   localparam logic [7:0] KEY_ENTER_DEF = 8'h28;
   localparam logic [7:0] KEY_PAUSE_DEF = 8'h13;

endpackage

// File: rtl/game_sequencer_key_edge.sv
// Turns "either keycode slot holds this key" into a single-cycle press event.
module key_edge (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] keycode0,
   input  logic [7:0] keycode1,
   input  logic [7:0] match,
   output logic       evt
);

   logic hit;
   logic lvl;
   logic lvl_d;

   // The null keycode means "no key" in the HID report, so it can never count as a press.
   assign hit = (match != 8'h00) && ((keycode0 == match) || (keycode1 == match));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         lvl   <= 1'b0;
         lvl_d <= 1'b0;
      end else begin
         lvl   <= hit;
         lvl_d <= lvl;
      end
   end

   assign evt = lvl & ~lvl_d;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: title/play/pause/hit/over sequencing, lives, score and invulnerability.
module game_sequencer
   import game_pkg::*;
#(
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned HIT_FRAMES    = 60,
   parameter int unsigned INVULN_FRAMES = 120,
   parameter logic [7:0]  KEY_ENTER     = KEY_ENTER_DEF,
   parameter logic [7:0]  KEY_PAUSE     = KEY_PAUSE_DEF,
   parameter int unsigned SCORE_W       = 16
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               vsync,
   input  logic [7:0]         keycode0,
   input  logic [7:0]         keycode1,
   input  logic               colliding,
   output logic [2:0]         state,
   output logic               run,
   output logic               pause,
   output logic               game_over,
   output logic [2:0]         lives,
   output logic [SCORE_W-1:0] score,
   output logic               invuln,
   output logic               respawn
);

   localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
   localparam logic [7:0] HIT_INIT   = 8'(HIT_FRAMES);
   localparam logic [7:0] INV_INIT   = 8'(INVULN_FRAMES);

   game_state_t cur_state;
   game_state_t next_state;
   logic [2:0]  vs_sync;
   logic        frame_tick;
   logic        enter_evt;
   logic        pause_evt;
   logic [7:0]  hit_cnt;
   logic [7:0]  inv_cnt;
   logic        struck;

   key_edge u_enter (
      .Clk      (Clk),
      .Reset    (Reset),
      .keycode0 (keycode0),
      .keycode1 (keycode1),
      .match    (KEY_ENTER),
      .evt      (enter_evt)
   );

   key_edge u_pause (
      .Clk      (Clk),
      .Reset    (Reset),
      .keycode0 (keycode0),
      .keycode1 (keycode1),
      .match    (KEY_PAUSE),
      .evt      (pause_evt)
   );

   // vsync comes from the pixel clock domain: two flops to settle it, a third to find its rising edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         vs_sync <= 3'b000;
      end else begin
         vs_sync <= {vs_sync[1:0], vsync};
      end
   end

   assign frame_tick = vs_sync[1] & ~vs_sync[2];
   assign struck     = frame_tick & colliding & (inv_cnt == 8'd0);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cur_state <= TITLE;
      end else begin
         cur_state <= next_state;
      end
   end

   always_comb begin
      next_state = TITLE;
      case (cur_state)
         TITLE:   next_state = enter_evt ? PLAY : TITLE;
         PLAY: begin
            // A collision wins over a pause request arriving in the same cycle.
            if (struck) begin
               next_state = (lives == 3'd1) ? OVER : HIT;
            end else if (pause_evt) begin
               next_state = PAUSE;
            end else begin
               next_state = PLAY;
            end
         end
         PAUSE:   next_state = (pause_evt | enter_evt) ? PLAY : PAUSE;
         HIT:     next_state = (frame_tick && hit_cnt == 8'd1) ? PLAY : HIT;
         OVER:    next_state = enter_evt ? TITLE : OVER;
         default: next_state = TITLE;
      endcase
   end

   always_comb begin
      run       = 1'b0;
      pause     = 1'b0;
      game_over = 1'b0;
      invuln    = 1'b0;
      case (cur_state)
         PLAY: begin
            run    = 1'b1;
            invuln = (inv_cnt != 8'd0);
         end
         PAUSE: begin
            pause  = 1'b1;
            invuln = (inv_cnt != 8'd0);
         end
         OVER:    game_over = 1'b1;
         default: ;
      endcase
   end

   assign state = cur_state;

   // Counters advance only on frame ticks; PAUSE and OVER fall through and hold everything.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         lives   <= LIVES_INIT;
         score   <= '0;
         hit_cnt <= 8'd0;
         inv_cnt <= 8'd0;
         respawn <= 1'b0;
      end else begin
         respawn <= (next_state == PLAY) && ((cur_state == TITLE) || (cur_state == HIT));
         case (cur_state)
            TITLE: begin
               lives   <= LIVES_INIT;
               score   <= '0;
               hit_cnt <= 8'd0;
               if (enter_evt) begin
                  inv_cnt <= INV_INIT;
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  if (score != {SCORE_W{1'b1}}) begin
                     score <= score + SCORE_W'(1);
                  end
                  if (inv_cnt != 8'd0) begin
                     inv_cnt <= inv_cnt - 8'd1;
                  end
                  if (struck) begin
                     lives   <= lives - 3'd1;
                     hit_cnt <= HIT_INIT;
                  end
               end
            end
            HIT: begin
               if (frame_tick) begin
                  hit_cnt <= hit_cnt - 8'd1;
                  if (hit_cnt == 8'd1) begin
                     inv_cnt <= INV_INIT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Central game-flow controller for the barrel-dodge game. It sequences title, play, pause, hit-recovery and game-over phases from USB keycodes and the collision flag. It owns the life counter, score and invulnerability window. It drives the run/pause enables consumed by the player, barrel and color-mapper blocks, replacing the ad-hoc pause/enter/lives logic in the player block.

Parameters:
START_LIVES, 3, lives loaded at reset and on title entry (1..7)
HIT_FRAMES, 60, frames frozen after a hit before respawn (1..255)
INVULN_FRAMES, 120, frames of collision immunity after respawn (0..255)
KEY_ENTER, 8'h28, HID usage code for start/resume/restart
KEY_PAUSE, 8'h13, HID usage code for pause toggle ("P")
SCORE_W, 16, score counter width

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
vsync  in  1  VGA vsync; frame timebase, asynchronous to Clk
keycode0  in  8  USB keycode slot 0
keycode1  in  8  USB keycode slot 1
colliding  in  1  player/barrel overlap flag (level)
state  out  3  current state encoding (debug/LED)
run  out  1  1 = world objects advance this frame
pause  out  1  1 = in PAUSE
game_over  out  1  1 = in OVER
lives  out  3  remaining lives
score  out  SCORE_W  frames survived in PLAY
invuln  out  1  1 = invulnerability window active (sprite blink)
respawn  out  1  one-Clk pulse: reset player/barrel positions

Behaviour:
- Reset (Reset=0, asynchronous): state=TITLE, lives=START_LIVES, score=0, hit_cnt=0, inv_cnt=0, all flag outputs 0, sync/edge registers cleared.
- frame_tick: vsync passes through a 2-FF synchronizer, then rising-edge detect. One-Clk pulse, 3 Clk after vsync rises. Exactly one tick per vsync rise.
- Key events: enter_lvl = (keycode0==KEY_ENTER)|(keycode1==KEY_ENTER); pause_lvl likewise. Both levels are registered. An event is a one-Clk pulse on the 0->1 transition of the registered level. A held key gives one event only. keycode 8'h00 never matches.
- TITLE: run=0, lives=START_LIVES, score=0. enter_evt -> PLAY, respawn=1 for that cycle, inv_cnt=INVULN_FRAMES.
- PLAY: run=1.
  - On frame_tick: score+1, saturating at all-ones. inv_cnt-1 if nonzero.
  - On frame_tick with colliding=1 and inv_cnt==0 (pre-decrement value): lives-1. If lives was 1 -> OVER (lives=0). Else -> HIT with hit_cnt=HIT_FRAMES.
  - pause_evt -> PAUSE.
  - Collision on a frame_tick takes priority over a same-cycle pause_evt; pause_evt is then discarded.
  - enter_evt is ignored in PLAY.
- HIT: run=0, invuln=0. On frame_tick: hit_cnt-1. The tick that decrements hit_cnt from 1 to 0 -> PLAY, with respawn=1 that cycle and inv_cnt=INVULN_FRAMES. Keys are ignored.
- PAUSE: run=0, pause=1. score, inv_cnt and lives are frozen. pause_evt or enter_evt -> PLAY with no respawn and counters unchanged.
- OVER: run=0, game_over=1, score held for display. enter_evt -> TITLE, which reloads lives and clears score in the cycle after entry.
- invuln = (inv_cnt!=0) in PLAY and PAUSE; 0 in all other states.
- Outputs are registered. run, pause and game_over change on the Clk edge that changes state.
- Reset mid-game returns to TITLE immediately; no respawn pulse is generated by reset.
- INVULN_FRAMES=0: immunity is disabled, and a collision on the first tick after respawn counts.
- State encoding: TITLE=0, PLAY=1, PAUSE=2, HIT=3, OVER=4. Values 5-7 are illegal and recover to TITLE on the next Clk.

Decomposition:
- Package game_pkg: game_state_t enum (the encoding above); constants KEY_ENTER_DEF=8'h28 and KEY_PAUSE_DEF=8'h13.
- Sub-module key_edge: takes two keycodes plus a match code and returns a one-Clk event. Instantiate it twice (enter, pause).
- The vsync synchronizer/edge detect is inline.

Test Plan:
- Reset low mid-PLAY with lives=1 -> same cycle: state=0, lives=3, score=0, run=0. Release reset, enter_evt -> state=1, respawn high exactly 1 Clk, invuln=1.
- PLAY with INVULN_FRAMES=120, colliding held 1 -> no life lost for 120 ticks. On tick 121: lives 3->2, state=3, run=0. After 60 further ticks: state=1, respawn pulse.
- Hold KEY_PAUSE in keycode1 for 500 Clk in PLAY -> one PAUSE entry only, score constant over 10 vsyncs. Release and re-press -> state=1, score resumes from the held value.
- Lives=1, collision on tick with inv_cnt=0 -> state=4, lives=0, game_over=1. Enter -> state=0. Next cycle: lives=3, score=0.
- Same Clk: frame_tick, colliding=1 with inv_cnt=0, and pause_evt -> lives decrements, state=3, pause stays 0.
- SCORE_W=4: run 20 ticks in PLAY with no collision -> score saturates at 15 and does not wrap.
